// File: rtl/ex_mdu_pkg.sv
// Shared operation codes, FSM encoding and decode helpers for the EX-stage
// RV32M multiply/divide unit.
package ex_mdu_pkg;

    localparam int ALU_OP_W = 8;
    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_OP_NOP    = 8'h00;
    localparam alu_op_t ALU_OP_ADD    = 8'h20;
    localparam alu_op_t ALU_OP_MUL    = 8'h40;
    localparam alu_op_t ALU_OP_MULH   = 8'h41;
    localparam alu_op_t ALU_OP_MULHSU = 8'h42;
    localparam alu_op_t ALU_OP_MULHU  = 8'h43;
    localparam alu_op_t ALU_OP_DIV    = 8'h44;
    localparam alu_op_t ALU_OP_DIVU   = 8'h45;
    localparam alu_op_t ALU_OP_REM    = 8'h46;
    localparam alu_op_t ALU_OP_REMU   = 8'h47;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    localparam int MDU_ITER = 32;
    localparam int CNT_W    = $clog2(MDU_ITER);

    // sel_hi_rem selects the high product word for mul ops, the remainder for div ops.
    typedef struct packed {
        logic is_m;
        logic is_div;
        logic sel_hi_rem;
        logic s1_signed;
        logic s2_signed;
    } mdu_op_t;

    function automatic mdu_op_t decode_op(input alu_op_t op);
        mdu_op_t d;
        d = '0;
        unique case (op)
            ALU_OP_MUL:    d = '{is_m: 1'b1, is_div: 1'b0, sel_hi_rem: 1'b0, s1_signed: 1'b1, s2_signed: 1'b1};
            ALU_OP_MULH:   d = '{is_m: 1'b1, is_div: 1'b0, sel_hi_rem: 1'b1, s1_signed: 1'b1, s2_signed: 1'b1};
            ALU_OP_MULHSU: d = '{is_m: 1'b1, is_div: 1'b0, sel_hi_rem: 1'b1, s1_signed: 1'b1, s2_signed: 1'b0};
            ALU_OP_MULHU:  d = '{is_m: 1'b1, is_div: 1'b0, sel_hi_rem: 1'b1, s1_signed: 1'b0, s2_signed: 1'b0};
            ALU_OP_DIV:    d = '{is_m: 1'b1, is_div: 1'b1, sel_hi_rem: 1'b0, s1_signed: 1'b1, s2_signed: 1'b1};
            ALU_OP_DIVU:   d = '{is_m: 1'b1, is_div: 1'b1, sel_hi_rem: 1'b0, s1_signed: 1'b0, s2_signed: 1'b0};
            ALU_OP_REM:    d = '{is_m: 1'b1, is_div: 1'b1, sel_hi_rem: 1'b1, s1_signed: 1'b1, s2_signed: 1'b1};
            ALU_OP_REMU:   d = '{is_m: 1'b1, is_div: 1'b1, sel_hi_rem: 1'b1, s1_signed: 1'b0, s2_signed: 1'b0};
            default:       d = '0;
        endcase
        return d;
    endfunction

    // Magnitude as an unsigned 32-bit value; 0x80000000 maps onto itself.
    function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/ex_mdu_step.sv
// One iteration of the MDU datapath: right-shifting shift-add multiply or
// restoring trial-subtract divide.
module mdu_step
    import ex_mdu_pkg::*;
(
    input  logic        is_div_i,
    input  logic [63:0] acc_i,   // mul: product accumulator; div: partial remainder in [32:0]
    input  logic [31:0] opa_i,   // mul: shifting multiplier; div: dividend/quotient shift register
    input  logic [31:0] opb_i,   // mul: multiplicand; div: divisor
    output logic [63:0] acc_o,
    output logic [31:0] opa_o
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [33:0] trial;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no latch is inferred.
        sum     = '0;
        shifted = '0;
        trial   = '0;
        acc_o   = acc_i;
        opa_o   = opa_i;
        if (!is_div_i) begin
            sum   = {1'b0, acc_i[63:32]} + (opa_i[0] ? {1'b0, opb_i} : 33'd0);
            acc_o = {sum, acc_i[31:1]};
            opa_o = {1'b0, opa_i[31:1]};
        end else begin
            shifted = {acc_i[31:0], opa_i[31]};
            trial   = {1'b0, shifted} - {2'b00, opb_i};
            if (!trial[33]) begin
                acc_o = {31'd0, trial[32:0]};
                opa_o = {opa_i[30:0], 1'b1};
            end else begin
                acc_o = {31'd0, shifted};
                opa_o = {opa_i[30:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: stalls the pipeline for the duration of
// an M operation, then presents the result for exactly one cycle.
module ex_mdu
    import ex_mdu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [ALU_OP_W-1:0] aluop_i,
    input  logic [31:0]         reg1_i,
    input  logic [31:0]         reg2_i,
    input  logic                cancel_i,
    output logic                stallreq_o,
    output logic [31:0]         result_o,
    output logic                result_valid_o
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      opa_q, opa_d;
    logic [31:0]      opb_q, opb_d;
    mdu_op_t          info_q, info_d;
    logic             neg_q, neg_d;
    logic [31:0]      result_q, result_d;

    mdu_op_t     dec;
    logic        s1_neg, s2_neg;
    logic [31:0] mag1, mag2;
    logic        div_zero, div_ovf;
    logic [63:0] step_acc;
    logic [31:0] step_opa;
    logic [63:0] prod;
    logic [31:0] mul_res, div_raw, div_res;

    assign dec      = decode_op(aluop_i);
    assign s1_neg   = dec.s1_signed & reg1_i[31];
    assign s2_neg   = dec.s2_signed & reg2_i[31];
    assign mag1     = abs32(reg1_i, dec.s1_signed);
    assign mag2     = abs32(reg2_i, dec.s2_signed);
    assign div_zero = (reg2_i == 32'd0);
    assign div_ovf  = dec.s1_signed && (reg1_i == 32'h8000_0000) && (reg2_i == 32'hFFFF_FFFF);

    mdu_step u_step (
        .is_div_i (info_q.is_div),
        .acc_i    (acc_q),
        .opa_i    (opa_q),
        .opb_i    (opb_q),
        .acc_o    (step_acc),
        .opa_o    (step_opa)
    );

    // Sign correction applied to the outcome of the final iteration.
    assign prod    = neg_q ? (~step_acc + 64'd1) : step_acc;
    assign mul_res = info_q.sel_hi_rem ? prod[63:32] : prod[31:0];
    assign div_raw = info_q.sel_hi_rem ? step_acc[31:0] : step_opa;
    assign div_res = neg_q ? (~div_raw + 32'd1) : div_raw;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        info_d     = info_q;
        neg_d      = neg_q;
        result_d   = result_q;
        stallreq_o = 1'b0;

        unique case (state_q)
            MDU_IDLE: begin
                if (dec.is_m) begin
                    stallreq_o = 1'b1;
                    info_d     = dec;
                    cnt_d      = '0;
                    acc_d      = '0;
                    if (dec.is_div) begin
                        opa_d = mag1;
                        opb_d = mag2;
                        neg_d = dec.sel_hi_rem ? s1_neg : (s1_neg ^ s2_neg);
                    end else begin
                        opa_d = mag2;
                        opb_d = mag1;
                        neg_d = s1_neg ^ s2_neg;
                    end
                    if (dec.is_div && div_zero) begin
                        result_d = dec.sel_hi_rem ? reg1_i : 32'hFFFF_FFFF;
                        state_d  = MDU_DONE;
                    end else if (dec.is_div && div_ovf) begin
                        result_d = dec.sel_hi_rem ? 32'd0 : 32'h8000_0000;
                        state_d  = MDU_DONE;
                    end else begin
                        state_d = MDU_BUSY;
                    end
                end
            end
            MDU_BUSY: begin
                stallreq_o = 1'b1;
                acc_d      = step_acc;
                opa_d      = step_opa;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MDU_ITER - 1)) begin
                    result_d = info_q.is_div ? div_res : mul_res;
                    state_d  = MDU_DONE;
                end
            end
            MDU_DONE: state_d = MDU_IDLE;
            default:  state_d = MDU_IDLE;
        endcase

        // A killed EX instruction releases the pipeline at once and never produces a result.
        if (cancel_i) begin
            stallreq_o = 1'b0;
            state_d    = MDU_IDLE;
            result_d   = result_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // NOTE: datapath registers are always loaded in IDLE before use, so they carry no reset.
    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        opa_q  <= opa_d;
        opb_q  <= opb_d;
        info_q <= info_d;
        neg_q  <= neg_d;
    end

    assign result_o       = result_q;
    assign result_valid_o = (state_q == MDU_DONE);

endmodule

// File: doc/ex_mdu.md
# ex_mdu

Iterative RV32M multiply/divide unit in the EX stage. It consumes the operation and operands latched by the ID/EX pipeline register. While an M-extension operation runs, it holds the pipeline through the stall controller, then presents a 32-bit result for one cycle so the EX stage result mux can forward it into EX/MEM. Non-M operations pass through untouched, with no stall.

## Interface
Parameters:
- none; operation codes and widths come from the shared defines file.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- aluop_i  in  `AluOpBus  operation from ID/EX (`ex_aluop`)
- reg1_i  in  32  rs1 operand (dividend / multiplicand)
- reg2_i  in  32  rs2 operand (divisor / multiplier)
- cancel_i  in  1  abort the in-flight operation (EX instruction killed)
- stallreq_o  out  1  stall request to ctrl (holds stall[3:0])
- result_o  out  32  registered result
- result_valid_o  out  1  high exactly in DONE

## Operation
- Recognised ops:
  - MUL: low 32 bits of the product.
  - MULH: signed×signed, high 32 bits.
  - MULHSU: signed×unsigned, high 32 bits.
  - MULHU: unsigned×unsigned, high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Every other aluop: IDLE, stallreq_o=0, result_valid_o=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE + M op + !cancel_i: latch operand magnitudes, the sign flags, and the op; clear counter. Go to BUSY, or to DONE for a special case.
  - BUSY: one shift-add (mul) or restoring-subtract (div) step per cycle; 5-bit counter 0..31. At count 31: apply sign correction, register the result, go to DONE.
  - DONE: result_valid_o=1, stallreq_o=0. Next cycle go to IDLE unconditionally, because ID/EX loads a new instruction or bubble at that edge.
- Sign rules:
  - Mul product is negated when the operand signs differ. Operand signedness follows the op (MULHSU treats rs2 as unsigned).
  - Quotient sign = s1^s2.
  - Remainder sign = dividend sign.
- Special cases, resolved in IDLE with no BUSY phase:
  - divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Datapath widths:
  - mul: 64-bit accumulator, 32-bit shifting multiplier.
  - div: 33-bit partial remainder, 32-bit quotient shift register.
  - All magnitudes are unsigned 32-bit; the abs of 0x80000000 is 0x80000000, taken as unsigned.

## Timing
- Reset values: state=IDLE, result_o=0, result_valid_o=0, stallreq_o=0, counter=0.
- Cycle T: M op is in EX, state IDLE; stallreq_o=1 combinationally.
- Normal op:
  - BUSY covers T+1..T+32, with stallreq_o=1.
  - DONE at T+33: result_valid_o=1, stallreq_o=0.
  - stallreq_o is high for 33 cycles in total.
- Special case: DONE at T+1; stallreq_o is high for 1 cycle.
- Cancel:
  - cancel_i forces stallreq_o=0 combinationally in every state.
  - Next state is IDLE; the result register does not update.
  - cancel_i in DONE drops result_valid_o the next cycle, as normal.
- rst mid-operation: IDLE next cycle, all outputs back to reset values; no partial result escapes.
- Back-to-back identical M ops: the second starts fresh in IDLE at T+34. No result reuse.
- Operands are sampled only at the IDLE→BUSY edge; later changes on reg1_i/reg2_i are ignored.

## Structure
- Shared defines file holds:
  - ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU, ALU_OP_DIV, ALU_OP_DIVU, ALU_OP_REM, ALU_OP_REMU
  - MDU state encodings MDU_IDLE, MDU_BUSY, MDU_DONE
  - MDU_ITER = 32
- One natural sub-module, `mdu_step`: the combinational single-iteration datapath (shift-add for mul, trial-subtract for div). ex_mdu owns the FSM, the counter, sign handling, and the result register.

## Test plan
- MUL 7 × 0xFFFFFFFD → result 0xFFFFFFEB; stallreq_o high 33 cycles; result_valid_o high 1 cycle.
- Operands 0xFFFFFFFF, 0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE
  - MULH → 0x00000000
  - MULHSU → 0xFFFFFFFF
- Division:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD
  - REM same operands → 0xFFFFFFFF
  - DIVU 100 / 7 → 14
  - REMU 100 / 7 → 2
- Special cases, each with stallreq_o high exactly 1 cycle:
  - DIV 5/0 → 0xFFFFFFFF
  - REMU 5/0 → 5
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000
  - REM same operands → 0
- Cancel: cancel_i at BUSY count 10 → stallreq_o low that cycle; IDLE next; result_valid_o never rises. A following MUL 3×4 returns 12 after full latency.
- Reset and non-M ops:
  - rst at BUSY count 20 → all outputs 0 next cycle.
  - ADD aluop → stallreq_o and result_valid_o stay 0.
